initialization_sequencer: RTL
=============================

# initialization_sequencer

Command-write sequencer for the 8259A control logic. It classifies each CPU write from the bus-control block as ICW1–ICW4 or OCW1–OCW3, and walks the mandatory ICW1→ICW2→(ICW3)→(ICW4) initialization order. It emits one-cycle write strobes, plus a registered copy of the written byte, to the initialization command word registers and the operation/interrupt-mask logic. It owns the "which word comes next" decision so that those register blocks stay pure storage.

## Interface
- No parameters.
- clock  input  1  system clock; all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- write_enable  input  1  one-cycle pulse, synchronous to clock; CPU write accepted this cycle
- address_0  input  1  A0 of the write
- internal_data_bus  input  8  written byte
- write_initial_command_word_1  output  1  ICW1 strobe
- write_initial_command_word_2  output  1  ICW2 strobe
- write_initial_command_word_3  output  1  ICW3 strobe
- write_initial_command_word_4  output  1  ICW4 strobe
- write_operation_control_word_1  output  1  OCW1 strobe
- write_operation_control_word_2  output  1  OCW2 strobe
- write_operation_control_word_3  output  1  OCW3 strobe
- command_data  output  8  registered byte accompanying any strobe
- initialization_done  output  1  high in READY state
- sequence_state  output  3  current state encoding, for debug/status

## Operation
- States: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- ICW1 detect: write_enable & !address_0 & data[4]. It is accepted in every state and always restarts the sequence:
  - assert the ICW1 strobe;
  - latch single_q = data[1] and ic4_q = data[0];
  - next state WAIT_ICW2.
- UNINIT: every write other than ICW1 is ignored (no strobe, no state change).
- WAIT_ICW2: a write with address_0=1 gives the ICW2 strobe. Next state:
  - WAIT_ICW3 if single_q=0;
  - else WAIT_ICW4 if ic4_q=1;
  - else READY.
- WAIT_ICW3: a write with address_0=1 gives the ICW3 strobe. Next state is WAIT_ICW4 if ic4_q=1, else READY.
- WAIT_ICW4: a write with address_0=1 gives the ICW4 strobe. Next state READY.
- In any WAIT_ICWn state, a write with address_0=0 that is not ICW1 is ignored. No strobe is issued and the state is held.
- READY decode:
  - address_0=1 → OCW1;
  - address_0=0, data[4:3]=00 → OCW2;
  - address_0=0, data[4:3]=01 → OCW3.
  - State stays READY.
- At most one strobe is asserted in any cycle (one-hot or zero).
- write_enable low: all strobes deassert and state is held.

## Timing
- Registered outputs: strobe and command_data are valid in the cycle after write_enable is sampled high. Each strobe is exactly one cycle wide.
- command_data updates only on an accepted write and holds otherwise.
- Back-to-back write_enable pulses on consecutive cycles are each processed. This gives consecutive strobes, e.g. ICW1 then ICW2.
- State transitions take effect on the same edge that registers the strobe.
- Reset values:
  - state UNINIT;
  - all strobes 0;
  - command_data 8'h00;
  - single_q 1, ic4_q 0;
  - initialization_done 0.
- Reset asserted mid-sequence aborts immediately. A subsequent ICW1 is required.
- ICW1 arriving in READY drops initialization_done on the following cycle.

## Configuration
- INIT_SEQ_CASCADE_EN defined: ICW3 state and strobe are present, with transitions as above.
- Not defined (single-chip build):
  - single_q is forced to 1;
  - the WAIT_ICW3 state is never entered;
  - write_initial_command_word_3 is tied 0;
  - ICW1 bit 1 is still forwarded on command_data.

## Structure
- Shared package holds:
  - state enum / localparams (UNINIT=0, WAIT_ICW2=1, WAIT_ICW3=2, WAIT_ICW4=3, READY=4);
  - ICW1 bit-position constants (IC4=0, SNGL=1, ICW1 marker=4);
  - OCW select constants (D4=4, D3=3).
- One sub-module: command_word_decoder. It is combinational and classifies address_0 and data into ICW1/OCW2/OCW3/other. The FSM and output registers stay in the top.

## Test plan
- Reset, then write ICW1 8'h13, then A0=1 writes 8'h20, 8'h01:
  - required strobes, each one cycle: ICW1, ICW2, ICW4;
  - initialization_done=1 after ICW4;
  - no ICW3 strobe.
- Cascade: ICW1 8'h11, then A0=1 writes 8'h08, 8'h04, 8'h01 → strobes ICW2, ICW3, ICW4 in order, with command_data 8'h08, 8'h04, 8'h01.
- ICW1 8'h12 (single, no ICW4), then ICW2 → READY immediately. Then:
  - A0=1 write 8'hFF → OCW1;
  - A0=0 8'h20 → OCW2;
  - A0=0 8'h0B → OCW3.
- Restart: in WAIT_ICW3, send ICW1 8'h13 → ICW1 strobe and state WAIT_ICW2. A0=0 write 8'h20 in WAIT_ICW2 → no strobe.
- Assert reset_n=0 mid-sequence (WAIT_ICW4) → outputs return to reset values asynchronously. After release, an A0=1 write gives no strobe.
- Build without INIT_SEQ_CASCADE_EN: ICW1 8'h11 + ICW2 → next state is WAIT_ICW4 and the ICW3 strobe never fires.

Source files
------------

// File: rtl/initialization_sequencer_pkg.sv
// Shared types and constants for the 8259A command-write sequencer.
package initialization_sequencer_pkg;

    typedef enum logic [2:0] {
        StUninit   = 3'd0,
        StWaitIcw2 = 3'd1,
        StWaitIcw3 = 3'd2,
        StWaitIcw4 = 3'd3,
        StReady    = 3'd4
    } seq_state_e;

    // ICW1 bit positions
    localparam int unsigned Icw1Ic4Bit    = 0;
    localparam int unsigned Icw1SnglBit   = 1;
    localparam int unsigned Icw1MarkerBit = 4;

    // OCW2/OCW3 select bits (A0=0 writes)
    localparam int unsigned OcwD4Bit = 4;
    localparam int unsigned OcwD3Bit = 3;

    typedef enum logic [1:0] {
        CmdOther = 2'd0,
        CmdIcw1  = 2'd1,
        CmdOcw2  = 2'd2,
        CmdOcw3  = 2'd3
    } cmd_class_e;

    typedef struct packed {
        logic icw1;
        logic icw2;
        logic icw3;
        logic icw4;
        logic ocw1;
        logic ocw2;
        logic ocw3;
    } strobes_t;

endpackage

// File: rtl/initialization_sequencer_if.sv
// CPU write bus in, command-word strobes and status out.
interface initialization_sequencer_if;
    logic       write_enable;
    logic       address_0;
    logic [7:0] internal_data_bus;
    logic       write_initial_command_word_1;
    logic       write_initial_command_word_2;
    logic       write_initial_command_word_3;
    logic       write_initial_command_word_4;
    logic       write_operation_control_word_1;
    logic       write_operation_control_word_2;
    logic       write_operation_control_word_3;
    logic [7:0] command_data;
    logic       initialization_done;
    logic [2:0] sequence_state;

    modport slave (
        input  write_enable, address_0, internal_data_bus,
        output write_initial_command_word_1, write_initial_command_word_2,
               write_initial_command_word_3, write_initial_command_word_4,
               write_operation_control_word_1, write_operation_control_word_2,
               write_operation_control_word_3, command_data, initialization_done,
               sequence_state
    );

    modport master (
        output write_enable, address_0, internal_data_bus,
        input  write_initial_command_word_1, write_initial_command_word_2,
               write_initial_command_word_3, write_initial_command_word_4,
               write_operation_control_word_1, write_operation_control_word_2,
               write_operation_control_word_3, command_data, initialization_done,
               sequence_state
    );
endinterface

// File: rtl/initialization_sequencer_command_word_decoder.sv
// Combinational classification of a write into ICW1 / OCW2 / OCW3 / other.
module initialization_sequencer_command_word_decoder
    import initialization_sequencer_pkg::*;
(
    input  logic       address_0,
    input  logic [1:0] data_4_3,
    output cmd_class_e cmd_class
);

    always_comb begin
        cmd_class = CmdOther;
        if (!address_0) begin
            if (data_4_3[1]) begin
                cmd_class = CmdIcw1;
            end else if (data_4_3[0]) begin
                cmd_class = CmdOcw3;
            end else begin
                cmd_class = CmdOcw2;
            end
        end
    end

endmodule

// File: rtl/initialization_sequencer.sv
// 8259A ICW/OCW write sequencer with registered one-cycle strobes.
// INIT_SEQ_CASCADE_EN enables the ICW3 step; otherwise the build is single-chip.
module initialization_sequencer
    import initialization_sequencer_pkg::*;
(
    input logic                        clock,
    input logic                        reset_n,
    initialization_sequencer_if.slave  bus
);

    seq_state_e state_q, state_d;
    logic       single_q, single_d;
    logic       ic4_q, ic4_d;
    strobes_t   strobe_q, strobe_d;
    logic [7:0] command_data_q, command_data_d;
    cmd_class_e cmd_class;

    initialization_sequencer_command_word_decoder command_word_decoder (
        .address_0 (bus.address_0),
        .data_4_3  ({bus.internal_data_bus[OcwD4Bit], bus.internal_data_bus[OcwD3Bit]}),
        .cmd_class (cmd_class)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StUninit;
            single_q       <= 1'b1;
            ic4_q          <= 1'b0;
            strobe_q       <= '0;
            command_data_q <= 8'h00;
        end else begin
            state_q        <= state_d;
            single_q       <= single_d;
            ic4_q          <= ic4_d;
            strobe_q       <= strobe_d;
            command_data_q <= command_data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        single_d = single_q;
        ic4_d    = ic4_q;
        if (bus.write_enable) begin
            if (cmd_class == CmdIcw1) begin
                state_d = StWaitIcw2;
`ifdef INIT_SEQ_CASCADE_EN
                single_d = bus.internal_data_bus[Icw1SnglBit];
`else
                single_d = 1'b1;
`endif
                ic4_d = bus.internal_data_bus[Icw1Ic4Bit];
            end else if (bus.address_0) begin
                unique case (state_q)
                    StWaitIcw2: begin
                        if (!single_q)  state_d = StWaitIcw3;
                        else if (ic4_q) state_d = StWaitIcw4;
                        else            state_d = StReady;
                    end
                    StWaitIcw3: state_d = ic4_q ? StWaitIcw4 : StReady;
                    StWaitIcw4: state_d = StReady;
                    default:    state_d = state_q;
                endcase
            end
        end
    end

    always_comb begin
        strobe_d = '0;
        if (bus.write_enable) begin
            if (cmd_class == CmdIcw1) begin
                strobe_d.icw1 = 1'b1;
            end else begin
                unique case (state_q)
                    StWaitIcw2: strobe_d.icw2 = bus.address_0;
                    StWaitIcw3: begin
`ifdef INIT_SEQ_CASCADE_EN
                        strobe_d.icw3 = bus.address_0;
`endif
                    end
                    StWaitIcw4: strobe_d.icw4 = bus.address_0;
                    StReady: begin
                        if (bus.address_0)            strobe_d.ocw1 = 1'b1;
                        else if (cmd_class == CmdOcw2) strobe_d.ocw2 = 1'b1;
                        else if (cmd_class == CmdOcw3) strobe_d.ocw3 = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
        // Only an accepted write (one that raises a strobe) refreshes the byte.
        command_data_d = (|strobe_d) ? bus.internal_data_bus : command_data_q;
    end

    assign bus.write_initial_command_word_1   = strobe_q.icw1;
    assign bus.write_initial_command_word_2   = strobe_q.icw2;
    assign bus.write_initial_command_word_3   = strobe_q.icw3;
    assign bus.write_initial_command_word_4   = strobe_q.icw4;
    assign bus.write_operation_control_word_1 = strobe_q.ocw1;
    assign bus.write_operation_control_word_2 = strobe_q.ocw2;
    assign bus.write_operation_control_word_3 = strobe_q.ocw3;
    assign bus.command_data                   = command_data_q;
    assign bus.initialization_done            = (state_q == StReady);
    assign bus.sequence_state                 = state_q;

endmodule
